memshare_shift_sched: RTL

Scheduler FSM for one SCU.memShare() operation. It walks a list of column shift values held in an external shift ROM. For each column it produces the `isGtr` compare flag and the `scu_memShare_busy` window consumed by the delta-FF reset generator. It also reads the resulting delta (skid) state back and emits the per-column circular-shift factor for the shared-memory permutation network. It sits between the layer controller (start/abort) and the shift ROM, delta reset generator and circular shifter.

---
 rtl/memshare_shift_sched.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/memshare_shift_sched.sv
// Column scheduler for one shared-memory shift operation: walks the shift ROM,
// flags isGtr per column and emits the circular-shift factor for each column.
module memshare_shift_sched #(
   parameter int Z       = 64,
   parameter int SHIFT_W = $clog2(Z),
   parameter int ADDR_W  = 8,
   parameter int COL_MAX = 16,
   parameter int CNT_W   = $clog2(COL_MAX + 1)
) (
   input  logic               sys_clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [ADDR_W-1:0]  base_addr_i,
   input  logic [CNT_W-1:0]   col_cnt_i,
   output logic               rom_ren_o,
   output logic [ADDR_W-1:0]  rom_addr_o,
   input  logic [SHIFT_W:0]   rom_rdata_i,
   input  logic               delta_i,
   output logic               isGtr_o,
   output logic               busy_o,
   output logic [SHIFT_W-1:0] shift_o,
   output logic               shift_valid_o,
   output logic               range_err_o,
   output logic               done_o
);

   localparam int            W     = SHIFT_W + 2;
   localparam logic [W-1:0]  Z_EXT = W'(Z);

   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      READ_COL_ADDR = 2'd1,
      SHIFT_GEN     = 2'd2,
      DONE          = 2'd3
   } state_t;

   state_t              state_r;
   state_t              fsm_nxt_s;
   state_t              state_nxt_s;

   logic [ADDR_W-1:0]   base_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    k_r;
   logic [SHIFT_W-1:0]  prev_r;

   logic                rom_ren_r;
   logic [ADDR_W-1:0]   rom_addr_r;
   logic                busy_r;
   logic                done_r;
   logic [SHIFT_W-1:0]  shift_r;
   logic                shift_valid_r;
   logic                range_err_r;

   logic                start_ok_s;
   logic [CNT_W:0]      k_inc_s;
   logic [ADDR_W-1:0]   addr_nxt_s;
   logic [W-1:0]        rdata_ext_s;
   logic [W-1:0]        tgt_ext_s;
   logic [W-1:0]        prev_ext_s;
   logic [W-1:0]        rel_ext_s;
   logic [W-1:0]        inv_ext_s;
   logic [W-1:0]        shift_ext_s;
   logic                range_s;
   logic                gtr_s;
   logic [SHIFT_W-1:0]  tgt_s;
   logic [SHIFT_W-1:0]  shift_nxt_s;

   // Start is honoured only without a simultaneous abort; abort wins over the FSM.
   assign start_ok_s  = start_i & ~abort_i;
   assign state_nxt_s = abort_i ? IDLE : fsm_nxt_s;
   assign k_inc_s     = {1'b0, k_r} + {{CNT_W{1'b0}}, 1'b1};

   // Next-state decode for the column walk.
   always_comb begin
      fsm_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_ok_s) begin
               if (col_cnt_i == {CNT_W{1'b0}}) begin
                  fsm_nxt_s = DONE;
               end else begin
                  fsm_nxt_s = READ_COL_ADDR;
               end
            end else begin
               fsm_nxt_s = IDLE;
            end
         end
         READ_COL_ADDR: fsm_nxt_s = SHIFT_GEN;
         SHIFT_GEN: begin
            if (k_inc_s < {1'b0, cnt_r}) begin
               fsm_nxt_s = READ_COL_ADDR;
            end else begin
               fsm_nxt_s = DONE;
            end
         end
         DONE:    fsm_nxt_s = IDLE;
         default: fsm_nxt_s = IDLE;
      endcase
   end

   // ROM address for the upcoming read; wraps modulo 2^ADDR_W.
   always_comb begin
      addr_nxt_s = '0;
      if (state_r == IDLE) begin
         addr_nxt_s = base_addr_i;
      end else begin
         addr_nxt_s = base_r + ADDR_W'(k_inc_s);
      end
   end

   // Target folding, relative shift and delta-dependent inversion.
   always_comb begin
      rdata_ext_s = W'(rom_rdata_i);
      prev_ext_s  = W'(prev_r);
      range_s     = (rdata_ext_s >= Z_EXT);
      if (range_s) begin
         tgt_ext_s = rdata_ext_s - Z_EXT;
      end else begin
         tgt_ext_s = rdata_ext_s;
      end
      gtr_s = (tgt_ext_s > prev_ext_s);
      if (tgt_ext_s >= prev_ext_s) begin
         rel_ext_s = tgt_ext_s - prev_ext_s;
      end else begin
         rel_ext_s = tgt_ext_s + Z_EXT - prev_ext_s;
      end
      // SKID state reverses the rotation direction: (Z - rel) mod Z.
      if (rel_ext_s == {W{1'b0}}) begin
         inv_ext_s = {W{1'b0}};
      end else begin
         inv_ext_s = Z_EXT - rel_ext_s;
      end
      if (delta_i) begin
         shift_ext_s = inv_ext_s;
      end else begin
         shift_ext_s = rel_ext_s;
      end
      tgt_s       = SHIFT_W'(tgt_ext_s);
      shift_nxt_s = SHIFT_W'(shift_ext_s);
   end

   // State register.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operation context, column progress and registered outputs.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         base_r        <= '0;
         cnt_r         <= '0;
         k_r           <= '0;
         prev_r        <= '0;
         rom_ren_r     <= 1'b0;
         rom_addr_r    <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         shift_r       <= '0;
         shift_valid_r <= 1'b0;
         range_err_r   <= 1'b0;
      end else begin
         if ((state_r == IDLE) && start_ok_s) begin
            base_r <= base_addr_i;
            cnt_r  <= col_cnt_i;
            k_r    <= '0;
            prev_r <= '0;
         end else if (state_r == SHIFT_GEN) begin
            prev_r <= tgt_s;
            k_r    <= CNT_W'(k_inc_s);
         end
         rom_ren_r <= (state_nxt_s == READ_COL_ADDR);
         if (state_nxt_s == READ_COL_ADDR) begin
            rom_addr_r <= addr_nxt_s;
         end
         busy_r        <= (state_nxt_s != IDLE);
         done_r        <= (state_nxt_s == DONE);
         // A shift computed in SHIFT_GEN is delivered even if abort arrives with it.
         shift_valid_r <= (state_r == SHIFT_GEN);
         range_err_r   <= (state_r == SHIFT_GEN) && range_s;
         if (state_r == SHIFT_GEN) begin
            shift_r <= shift_nxt_s;
         end
      end
   end

   assign rom_ren_o     = rom_ren_r;
   assign rom_addr_o    = rom_addr_r;
   assign busy_o        = busy_r;
   assign done_o        = done_r;
   assign shift_o       = shift_r;
   assign shift_valid_o = shift_valid_r;
   assign range_err_o   = range_err_r;
   assign isGtr_o       = (state_r == SHIFT_GEN) && gtr_s;

endmodule
